// File: rtl/sift_kp_extract_if.sv
// Sample-in / keypoint-out bus for sift_kp_extract.
// The producer/consumer side uses master; the extractor uses slave.
interface sift_kp_extract_if #(
  parameter int DATA_W = 8
);
  localparam int REC_W = 1 + 2 * 16 + DATA_W;

  logic                     in_en;
  logic signed [DATA_W-1:0] diff0;
  logic signed [DATA_W-1:0] diff1;
  logic signed [DATA_W-1:0] diff2;
  logic [REC_W-1:0]         kp_data;
  logic                     kp_valid;
  logic                     kp_ready;

  modport master (
    output in_en, diff0, diff1, diff2, kp_ready,
    input  kp_data, kp_valid
  );

  modport slave (
    input  in_en, diff0, diff1, diff2, kp_ready,
    output kp_data, kp_valid
  );
endinterface

// File: rtl/sift_kp_extract.sv
// 3x3x3 DoG extremum detector with keypoint record FIFO.
// Define SIFT_KP_COUNT_EN to add per-frame kp_count/kp_count_last outputs.
module sift_kp_extract #(
  parameter int DATA_W     = 8,
  parameter int IMG_W      = 512,
  parameter int IMG_H      = 512,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-2:0] thresh,
  sift_kp_extract_if.slave  kp_if,
  output logic              frame_done,
  output logic              overflow
`ifdef SIFT_KP_COUNT_EN
  ,
  output logic [15:0]       kp_count,
  output logic [15:0]       kp_count_last
`endif
);
  localparam int REC_W = 1 + 2 * 16 + DATA_W;
  localparam int XW    = $clog2(IMG_W);
  localparam int YW    = $clog2(IMG_H);
  localparam int AW    = $clog2(FIFO_DEPTH);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  logic signed [DATA_W-1:0] dif [3];
  logic signed [DATA_W-1:0] col [3][3];
  logic signed [DATA_W-1:0] lb0_q [3][IMG_W];
  logic signed [DATA_W-1:0] lb1_q [3][IMG_W];
  logic signed [DATA_W-1:0] win_q [3][3][3];

  logic        decide, last;
  logic        s1_vld_q, s1_last_q;
  logic [15:0] s1_cx_q, s1_cy_q;

  logic signed [DATA_W-1:0] cen;
  logic signed [DATA_W:0]   cen_x, th_x;
  logic                     gt_all, lt_all;
  logic                     is_max, is_min;

  logic             s2_vld_q, s2_last_q;
  logic [REC_W-1:0] s2_rec_q;

  logic [REC_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]      wp_q, rp_q;
  logic             fifo_full, fifo_empty;
  logic             rd, wr_ok;
  logic             frame_done_q, overflow_q;

  // Raster position of the incoming sample
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (kp_if.in_en) begin
      if (x_q == XW'(IMG_W - 1)) begin
        x_d = '0;
        y_d = (y_q == YW'(IMG_H - 1)) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Position counters
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // Column of three rows (y-2, y-1, y) at the incoming x
  always_comb begin
    dif[0] = kp_if.diff0;
    dif[1] = kp_if.diff1;
    dif[2] = kp_if.diff2;
    for (int l = 0; l < 3; l++) begin
      col[l][0] = lb1_q[l][x_q];
      col[l][1] = lb0_q[l][x_q];
      col[l][2] = dif[l];
    end
  end

  // Line buffers and window shift; contents need no reset
  always_ff @(posedge clk) begin
    if (kp_if.in_en) begin
      for (int l = 0; l < 3; l++) begin
        lb0_q[l][x_q] <= dif[l];
        lb1_q[l][x_q] <= lb0_q[l][x_q];
        for (int r = 0; r < 3; r++) begin
          win_q[l][0][r] <= win_q[l][1][r];
          win_q[l][1][r] <= win_q[l][2][r];
          win_q[l][2][r] <= col[l][r];
        end
      end
    end
  end

  // Centre (x-1, y-1) is interior only once x>=2 and y>=2
  always_comb begin
    decide = kp_if.in_en && (x_q >= XW'(2)) && (y_q >= YW'(2));
    last   = kp_if.in_en && (x_q == XW'(IMG_W - 1))
             && (y_q == YW'(IMG_H - 1));
  end

  // Stage 1: decision tag travelling with the window
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_cx_q   <= '0;
      s1_cy_q   <= '0;
    end else begin
      s1_vld_q  <= decide;
      s1_last_q <= last;
      if (decide) begin
        s1_cx_q <= 16'(x_q) - 16'd1;
        s1_cy_q <= 16'(y_q) - 16'd1;
      end
    end
  end

  // Strict extremum against all 26 neighbours plus contrast test
  always_comb begin
    cen    = win_q[1][1][1];
    gt_all = 1'b1;
    lt_all = 1'b1;
    for (int l = 0; l < 3; l++)
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 3; r++)
          if (!(l == 1 && c == 1 && r == 1)) begin
            if (cen <= win_q[l][c][r]) gt_all = 1'b0;
            if (cen >= win_q[l][c][r]) lt_all = 1'b0;
          end
    cen_x  = {cen[DATA_W-1], cen};
    th_x   = $signed({2'b00, thresh});
    is_max = gt_all && (cen_x > th_x);
    is_min = lt_all && (cen_x < -th_x);
  end

  // Stage 2: registered compare result and record
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld_q  <= 1'b0;
      s2_last_q <= 1'b0;
      s2_rec_q  <= '0;
    end else begin
      s2_vld_q  <= s1_vld_q && (is_max || is_min);
      s2_last_q <= s1_last_q;
      s2_rec_q  <= {is_max, s1_cy_q, s1_cx_q, cen};
    end
  end

  // FIFO status; a read frees a slot for a same-cycle write
  always_comb begin
    fifo_empty = (wp_q == rp_q);
    fifo_full  = ((wp_q - rp_q) == (AW + 1)'(FIFO_DEPTH));
    rd         = !fifo_empty && kp_if.kp_ready;
    wr_ok      = s2_vld_q && (!fifo_full || rd);
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wp_q[AW-1:0]] <= s2_rec_q;
  end

  // FIFO pointers, overflow flag and frame-end pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q         <= '0;
      rp_q         <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      if (wr_ok) wp_q <= wp_q + 1'b1;
      if (rd) rp_q <= rp_q + 1'b1;
      if (s2_vld_q && !wr_ok) overflow_q <= 1'b1;
      frame_done_q <= s2_last_q;
    end
  end

  // Output drive; head record is zero while empty
  always_comb begin
    kp_if.kp_valid = !fifo_empty;
    kp_if.kp_data  = fifo_empty ? '0 : mem_q[rp_q[AW-1:0]];
    frame_done     = frame_done_q;
    overflow       = overflow_q;
  end

`ifdef SIFT_KP_COUNT_EN
  logic [15:0] cnt_q, cnt_last_q, cnt_inc;

  // Saturating count including the current write
  always_comb begin
    cnt_inc = (wr_ok && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  end

  // Per-frame kept-record counter, latched at frame end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      cnt_last_q <= '0;
    end else if (s2_last_q) begin
      cnt_last_q <= cnt_inc;
      cnt_q      <= '0;
    end else begin
      cnt_q <= cnt_inc;
    end
  end

  assign kp_count      = cnt_q;
  assign kp_count_last = cnt_last_q;
`endif
endmodule
